// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the L2-to-memory responder and the cache models.
package mem_bus_responder_pkg;

    // Defaults shared with the L2 controller
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 64;
    localparam int DEF_BURST_LEN = 4;

    // Replacement policy and debug switches used by the cache models
    localparam int RANDOM = 0;
    localparam int PLRU   = 1;
    localparam int LRU    = 2;
    localparam int OFF    = 0;
    localparam int ON     = 1;

    // Responder FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT,
        ST_GAP,
        ST_DONE
    } state_t;

    // Counter width that stays legal when the count range is a single value
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_responder_store.sv
// Backing store: synchronous write, combinational read, single index port.
module mem_store #(
    parameter int DEPTH = 1024,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic                     we,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents are deliberately not reset so they survive a bus reset
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory end of the L2 request/strobe protocol: fixed latency, then a
// BURST_LEN-beat line transfer with one stb pulse every two cycles.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int LATENCY     = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addrstb,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              stb,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int BEAT_W = width_min1(BURST_LEN);
    localparam int LAT_W  = width_min1(LATENCY);

    state_t              state, state_d;
    logic [IDX_W-1:0]    base_q;
    logic                we_q;
    logic [LAT_W-1:0]    lat_q;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                accept, done_txn, mem_we, last_beat;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   rdata;
    logic                unused_addr;

    // Only the word-index bits matter; the rest are ignored by design
    assign unused_addr = ^addr;
    assign last_beat   = (beat_q == BEAT_W'(BURST_LEN - 1));
    // Index follows the next beat so a read beat can be registered on entry
    assign mem_idx     = base_q + IDX_W'(beat_d);
    assign busy        = (state != ST_IDLE);

    mem_store #(.DEPTH(DEPTH_WORDS), .W(DATA_W)) u_store (
        .clk   (clk),
        .idx   (mem_idx),
        .we    (mem_we),
        .wdata (data_in),
        .rdata (rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next state, beat strobe and write enable; addrstb low aborts mid-line
    always_comb begin
        state_d  = state;
        beat_d   = beat_q;
        accept   = 1'b0;
        done_txn = 1'b0;
        stb      = 1'b0;
        data_oe  = 1'b0;
        mem_we   = 1'b0;
        case (state)
            ST_IDLE: if (addrstb) begin
                accept  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!addrstb) state_d = ST_IDLE;
                else if (lat_q == '0) begin
                    state_d = ST_BEAT;
                    beat_d  = '0;
                end
            end
            ST_BEAT: begin
                stb     = 1'b1;
                data_oe = !we_q;
                if (!addrstb) state_d = ST_IDLE;
                else begin
                    mem_we  = we_q;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!addrstb) state_d = ST_IDLE;
                else if (last_beat) begin
                    done_txn = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    state_d = ST_BEAT;
                end
            end
            ST_DONE: if (!addrstb) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch line base and direction at acceptance; never re-read afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            we_q   <= 1'b0;
        end else if (accept) begin
            base_q <= addr[BYTE_W +: IDX_W] & ~IDX_W'(BURST_LEN - 1);
            we_q   <= we;
        end
    end

    // Latency countdown and beat index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q  <= '0;
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
            if (accept)                             lat_q <= LAT_W'(LATENCY - 1);
            else if (state == ST_WAIT && lat_q != '0) lat_q <= lat_q - 1'b1;
        end
    end

    // Read beat register; holds its value between beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              data_out <= '0;
        else if (state_d == ST_BEAT && !we_q)    data_out <= rdata;
    end

    // Completed-transaction counters, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (done_txn) begin
            if (we_q) wr_count <= wr_count + 1'b1;
            else      rd_count <= rd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (LATENCY=3, BURST_LEN=4, DEPTH=1024).
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addrstb;
    logic [31:0] addr;
    logic        we;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        data_oe, stb, busy;
    logic [15:0] rd_count, wr_count;

    int checks = 0;
    int errors = 0;

    // per-transaction observations
    int          nb;
    int          stb_at [4];
    logic [63:0] rd [4];
    bit          oe_bad;
    bit          done_bad;

    logic [3:0][63:0] dw, dz;

    mem_bus_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addrstb  (addrstb),
        .addr     (addr),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .stb      (stb),
        .busy     (busy),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One 4-phase transaction. Counts negedges after the acceptance edge.
    // abort_after=k drops addrstb right after the k-th beat's edge (0 = never).
    // hold = extra cycles addrstb stays high in DONE.
    task automatic txn(input logic [31:0] a, input logic w, input logic [3:0][63:0] d,
                       input int abort_after, input int hold);
        int n;
        nb = 0; oe_bad = 0; done_bad = 0;
        for (int i = 0; i < 4; i++) begin stb_at[i] = -1; rd[i] = '0; end
        @(posedge clk); #1;
        addr = a; we = w; data_in = d[0]; addrstb = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(negedge clk); n++;
            if (data_oe !== (stb && !w)) oe_bad = 1;
            if (stb) begin
                if (nb < 4) begin stb_at[nb] = n; rd[nb] = data_out; end
                nb++;
                if (nb == abort_after) begin
                    @(posedge clk); #1 addrstb = 1'b0;
                    @(negedge clk);
                    chk("abort_gap_busy", busy, 1);
                    @(posedge clk); #1;
                    chk("abort_idle_busy", busy, 0);
                    chk("abort_idle_stb", stb, 0);
                    return;
                end
                @(posedge clk); #1;
                if (nb < 4) data_in = d[nb];
            end else if (nb >= 4 && n >= stb_at[3] + 2) begin
                break;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (stb !== 1'b0 || busy !== 1'b1) done_bad = 1;
        end
        @(posedge clk); #1 addrstb = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; addrstb = 1'b1; addr = 32'h40; we = 1'b0; data_in = '0;

        // reset held with a pending request
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stb", stb, 0);
        chk("rst_oe", data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count", wr_count, 0);
        addrstb = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // write line at 0x40 (words 8..11)
        dw = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        dz = '0;
        txn(32'h0000_0040, 1'b1, dw, 0, 0);
        chk("w1_beats", nb, 4);
        chk("w1_first_stb", stb_at[0], 4);
        chk("w1_stb2", stb_at[1], 6);
        chk("w1_stb4", stb_at[3], 10);
        chk("w1_no_oe", oe_bad, 0);
        chk("w1_wr_count", wr_count, 1);

        // read it back
        txn(32'h0000_0040, 1'b0, dz, 0, 0);
        chk("r1_beats", nb, 4);
        chk("r1_first_stb", stb_at[0], 4);
        chk("r1_d0", rd[0], 64'h1111_1111_1111_1111);
        chk("r1_d1", rd[1], 64'h2222_2222_2222_2222);
        chk("r1_d2", rd[2], 64'h3333_3333_3333_3333);
        chk("r1_d3", rd[3], 64'h4444_4444_4444_4444);
        chk("r1_oe_only_stb", oe_bad, 0);
        chk("r1_rd_count", rd_count, 1);
        chk("r1_wr_count", wr_count, 1);
        @(negedge clk);
        chk("dout_hold", data_out, 64'h4444_4444_4444_4444);
        chk("oe_idle", data_oe, 0);

        // unaligned read: word 11 still starts at line base 8
        txn(32'h0000_0058, 1'b0, dz, 0, 0);
        chk("unal_d0", rd[0], 64'h1111_1111_1111_1111);
        chk("unal_d3", rd[3], 64'h4444_4444_4444_4444);
        chk("unal_rd_count", rd_count, 2);

        // aliasing write above the array, read back at 0x40
        dw = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        txn(32'h0000_2040, 1'b1, dw, 0, 0);
        chk("wrap_wr_count", wr_count, 2);
        txn(32'h0000_0040, 1'b0, dz, 0, 0);
        chk("wrap_d0", rd[0], 64'hAAAA_AAAA_AAAA_AAAA);
        chk("wrap_d3", rd[3], 64'hDDDD_DDDD_DDDD_DDDD);
        chk("wrap_rd_count", rd_count, 3);

        // abort: prefill line 0, then partial overwrite of 2 beats
        dw = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
              64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
        txn(32'h0000_0000, 1'b1, dw, 0, 0);
        chk("pre_wr_count", wr_count, 3);
        dw = {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
              64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
        txn(32'h0000_0000, 1'b1, dw, 2, 0);
        chk("abort_beats", nb, 2);
        chk("abort_wr_count", wr_count, 3);

        // read line 0 and hold addrstb 5 cycles in DONE
        txn(32'h0000_0000, 1'b0, dz, 0, 5);
        chk("abort_w0", rd[0], 64'h6666_0000_0000_0000);
        chk("abort_w1", rd[1], 64'h6666_0000_0000_0001);
        chk("abort_w2", rd[2], 64'h5555_0000_0000_0002);
        chk("abort_w3", rd[3], 64'h5555_0000_0000_0003);
        chk("hold_no_retxn", done_bad, 0);
        chk("hold_rd_count", rd_count, 4);
        txn(32'h0000_0000, 1'b0, dz, 0, 0);
        chk("reaccept_beats", nb, 4);
        chk("reaccept_rd_count", rd_count, 5);

        // async reset mid-transaction keeps array contents
        @(posedge clk); #1 addr = 32'h40; we = 1'b0; addrstb = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd_count", rd_count, 0);
        chk("arst_wr_count", wr_count, 0);
        addrstb = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        txn(32'h0000_0040, 1'b0, dz, 0, 0);
        chk("arst_keep_d0", rd[0], 64'hAAAA_AAAA_AAAA_AAAA);
        chk("arst_rd_count_after", rd_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Synthesizable main-memory responder: the memory end of the L2-to-memory request/strobe protocol.
- Accepts line requests from the L2 controller (addrstb, addr, we), waits a fixed access latency, then transfers a cache line as BURST_LEN 64-bit beats, pulsing stb once per beat.
- Holds the backing store in an internal word array.
- Replaces the behavioural memory model in synthesizable builds.

Parameters:
- ADDR_W, 32, request address width (byte address).
- DATA_W, 64, beat width in bits.
- DEPTH_WORDS, 1024, backing-store depth in DATA_W words; power of two.
- BURST_LEN, 4, beats per line; power of two, at least 1.
- LATENCY, 3, cycles from request acceptance to first beat; at least 1.
- CNT_W, 16, width of the transaction counters.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addrstb  in  1  request strobe from L2; level, held high for the whole transaction (4-phase).
- addr  in  ADDR_W  request byte address; stable while addrstb is high.
- we  in  1  1 = line write, 0 = line read; stable while addrstb is high.
- data_in  in  DATA_W  write beat from L2.
- data_out  out  DATA_W  read beat to L2.
- data_oe  out  1  high exactly while data_out carries a valid read beat; drives the external tristate.
- stb  out  1  one-cycle beat strobe.
- busy  out  1  high in every state except IDLE.
- rd_count  out  CNT_W  completed read transactions.
- wr_count  out  CNT_W  completed write transactions.

Behaviour:
- Reset values: stb=0, data_oe=0, data_out=0, busy=0, rd_count=0, wr_count=0, FSM=IDLE. The storage array is not reset.
- Word index = addr[log2(DATA_W/8) +: log2(DEPTH_WORDS)]. Addresses above the array wrap modulo DEPTH_WORDS.
- Line base = word index with its low log2(BURST_LEN) bits cleared. Beat k uses base+k, aligned, no critical-word-first.
- addr and we are captured at acceptance and not re-read afterwards.
- FSM states:
  - IDLE: addrstb=1 -> accept, latch addr/we, load latency counter with LATENCY-1, go to WAIT.
  - WAIT: count down; at 0 go to BEAT with beat=0.
  - BEAT: stb=1 for one cycle.
    - Read: data_out=mem[base+beat] and data_oe=1 in the same cycle.
    - Write: mem[base+beat] <= data_in at the end of this cycle.
    - Then go to GAP.
  - GAP: stb=0, data_oe=0; beat++. If the completed beat was BURST_LEN-1, increment rd_count or wr_count and go to DONE; otherwise go to BEAT.
  - DONE: wait for addrstb=0, then go to IDLE.
- Timing:
  - Beats are spaced two cycles apart (BEAT, GAP), so a registered requester can advance data_in on seeing stb.
  - Write beat 0 must be valid on data_in when addrstb rises.
  - First stb occurs LATENCY+1 cycles after the cycle in which addrstb is first sampled high.
  - Whole transaction: LATENCY + 2*BURST_LEN cycles from acceptance to DONE.
- Abort: addrstb=0 in WAIT, BEAT or GAP -> go to IDLE next cycle, stb=0, data_oe=0, no counter increment. Beats already written stay written.
- No re-accept in DONE. A new request needs addrstb to fall, then rise.
- Counters wrap at 2^CNT_W.
- Async reset mid-transaction: immediate return to reset values. Array contents are retained.
- data_out holds its last value when data_oe=0.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, WAIT, BEAT, GAP, DONE).
  - Replacement/debug constants already used by the cache models (RANDOM/PLRU/LRU, OFF/ON), unchanged.
  - Default DATA_W, ADDR_W and BURST_LEN shared with the L2 controller.
- One sub-module, mem_store: single-port synchronous-write, combinational-read DEPTH_WORDS x DATA_W array with index and write-enable ports. The FSM stays in the top module.

Test Plan:
- Reset: hold rst_n=0 with addrstb=1 -> stb=0, data_oe=0, busy=0, counters 0; no acceptance until release.
- Write then read, addr=0x0000_0040, data 0x11..11, 0x22..22, 0x33..33, 0x44..44 (BURST_LEN=4, LATENCY=3):
  - Write: 4 stb pulses; first stb 4 cycles after acceptance, then every 2 cycles; wr_count=1.
  - Read of the same address: data_out = the same 4 words in order, with data_oe high only on stb cycles; rd_count=1.
- Unaligned address: read addr=0x0000_0058 -> beats come from words 8..11 (line base 8), not from 11 onward.
- Wrap: write addr = DEPTH_WORDS*8 + 0x40 -> then reading addr=0x40 returns the written data.
- Abort: write drops addrstb after beat 1 -> words 0-1 updated, words 2-3 unchanged, wr_count unchanged, FSM back in IDLE next cycle.
- Handshake: addrstb held high after DONE for 5 cycles -> no second transaction; the next request is accepted only after addrstb goes low then high.
